uart_mmio: RTL and testbench

Memory-mapped UART controller for RISCuinho-NG, between the CPU data bus and the `rs232_sim` serial port model. CPU stores go into a TX FIFO. The TX FIFO drains as paced single-cycle `wr_en` pulses to `rs232_sim`. An RX poller issues `rd_en` probes and captures returned bytes into an RX FIFO, which the CPU reads through a DATA register. Status, control and a level interrupt complete the block.

---
 rtl/uart_mmio.sv | 206 ++++++++++++++++++++
 tb/tb_uart_mmio.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_mmio.sv
// uart_mmio: CPU-facing UART controller. Buffers CPU stores in a TX FIFO that
// drains as paced wr_en strobes, polls the serial model for RX bytes into an
// RX FIFO, and exposes DATA/STATUS/CTRL registers plus a level interrupt.
module uart_mmio #(
  parameter int unsigned TX_DEPTH = 8,
  parameter int unsigned RX_DEPTH = 8,
  parameter int unsigned TX_GAP   = 4,
  parameter int unsigned RX_POLL  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bus_sel,
  input  logic        bus_we,
  input  logic [1:0]  bus_addr,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        bus_ready,
  output logic        tx_wr_en,
  output logic [7:0]  tx_wr_data,
  output logic        rx_rd_en,
  input  logic [7:0]  rx_rd_data,
  input  logic        rx_rd_valid,
  output logic        irq
);

  localparam int unsigned TX_AW  = $clog2(TX_DEPTH);
  localparam int unsigned TX_CW  = TX_AW + 1;
  localparam int unsigned RX_AW  = $clog2(RX_DEPTH);
  localparam int unsigned RX_CW  = RX_AW + 1;
  localparam int unsigned GAP_W  = $clog2(TX_GAP + 1);
  localparam int unsigned POLL_W = $clog2(RX_POLL + 1);

  localparam logic [1:0] TXS_IDLE  = 2'd0;
  localparam logic [1:0] TXS_SEND  = 2'd1;
  localparam logic [1:0] TXS_GAP   = 2'd2;
  localparam logic [1:0] RXS_WAIT  = 2'd0;
  localparam logic [1:0] RXS_PROBE = 2'd1;
  localparam logic [1:0] RXS_CAPT  = 2'd2;

  logic [7:0]        tx_mem_q [TX_DEPTH];
  logic [TX_AW-1:0]  tx_wp_q, tx_rp_q;
  logic [TX_CW-1:0]  tx_cnt_q, tx_cnt_d;
  logic [7:0]        rx_mem_q [RX_DEPTH];
  logic [RX_AW-1:0]  rx_wp_q, rx_rp_q;
  logic [RX_CW-1:0]  rx_cnt_q, rx_cnt_d;

  logic [1:0]        tx_state_q, tx_state_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [1:0]        rx_state_q, rx_state_d;
  logic [POLL_W-1:0] poll_q, poll_d;

  logic              tx_drop_q;
  logic [3:0]        ctrl_q;

  logic [31:0]       bus_rdata_q;
  logic              bus_ready_q;
  logic              tx_wr_en_q;
  logic [7:0]        tx_wr_data_q;
  logic              rx_rd_en_q;
  logic              irq_q;

  logic acc_wr, acc_rd;
  logic tx_full, tx_empty, tx_idle, rx_full, rx_empty;
  logic tx_push, tx_pop, rx_push, rx_pop;
  logic [31:0] status, rd_mux;
  logic unused_wdata;

  assign acc_wr   = bus_sel & bus_we;
  assign acc_rd   = bus_sel & ~bus_we;
  assign tx_full  = (tx_cnt_q == TX_CW'(TX_DEPTH));
  assign tx_empty = (tx_cnt_q == '0);
  assign tx_idle  = tx_empty & (tx_state_q == TXS_IDLE);
  assign rx_full  = (rx_cnt_q == RX_CW'(RX_DEPTH));
  assign rx_empty = (rx_cnt_q == '0);

  // Full/empty are judged on pre-edge counts, so a write to a full FIFO drops
  // even when the sender pops in the same cycle.
  assign tx_push  = acc_wr & (bus_addr == 2'd0) & ~tx_full;
  assign tx_pop   = (tx_state_q == TXS_SEND);
  assign rx_push  = (rx_state_q == RXS_CAPT) & rx_rd_valid;
  assign rx_pop   = acc_rd & (bus_addr == 2'd0) & ~rx_empty;
  assign tx_cnt_d = tx_cnt_q + TX_CW'(tx_push) - TX_CW'(tx_pop);
  assign rx_cnt_d = rx_cnt_q + RX_CW'(rx_push) - RX_CW'(rx_pop);

  assign status = {12'd0, 4'(rx_cnt_q), 4'd0, 4'(tx_cnt_q),
                   4'd0, tx_drop_q, tx_idle, tx_full, ~rx_empty};
  assign unused_wdata = ^bus_wdata[31:8];

  // Read-data select for the register map
  always_comb begin
    rd_mux = '0;
    case (bus_addr)
      2'd0:    rd_mux = {24'd0, rx_empty ? 8'd0 : rx_mem_q[rx_rp_q]};
      2'd1:    rd_mux = status;
      2'd2:    rd_mux = {28'd0, ctrl_q};
      default: rd_mux = '0;
    endcase
  end

  // TX sequencer: one-cycle SEND, then TX_GAP cycles of GAP before IDLE
  always_comb begin
    tx_state_d = tx_state_q;
    gap_d      = gap_q;
    case (tx_state_q)
      TXS_IDLE: if (ctrl_q[0] && !tx_empty) tx_state_d = TXS_SEND;
      TXS_SEND: begin
        tx_state_d = TXS_GAP;
        gap_d      = '0;
      end
      TXS_GAP: begin
        if (gap_q == GAP_W'(TX_GAP - 1)) tx_state_d = TXS_IDLE;
        else                             gap_d      = gap_q + GAP_W'(1);
      end
      default: tx_state_d = TXS_IDLE;
    endcase
  end

  // RX poller: wait RX_POLL cycles (saturating while blocked), probe, capture
  always_comb begin
    rx_state_d = rx_state_q;
    poll_d     = poll_q;
    case (rx_state_q)
      RXS_WAIT: begin
        if (poll_q == POLL_W'(RX_POLL - 1)) begin
          if (ctrl_q[1] && !rx_full) rx_state_d = RXS_PROBE;
        end else begin
          poll_d = poll_q + POLL_W'(1);
        end
      end
      RXS_PROBE: rx_state_d = RXS_CAPT;
      RXS_CAPT: begin
        rx_state_d = RXS_WAIT;
        poll_d     = '0;
      end
      default: begin
        rx_state_d = RXS_WAIT;
        poll_d     = '0;
      end
    endcase
  end

  // FIFO storage; contents need no reset since pointers/counts define validity
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem_q[tx_wp_q] <= bus_wdata[7:0];
    if (rx_push) rx_mem_q[rx_wp_q] <= rx_rd_data;
  end

  // FIFO pointers, FSM state and control/status registers
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wp_q    <= '0;
      tx_rp_q    <= '0;
      tx_cnt_q   <= '0;
      rx_wp_q    <= '0;
      rx_rp_q    <= '0;
      rx_cnt_q   <= '0;
      tx_state_q <= TXS_IDLE;
      gap_q      <= '0;
      rx_state_q <= RXS_WAIT;
      poll_q     <= '0;
      tx_drop_q  <= 1'b0;
      ctrl_q     <= 4'b0011;
    end else begin
      if (tx_push) tx_wp_q <= tx_wp_q + TX_AW'(1);
      if (tx_pop)  tx_rp_q <= tx_rp_q + TX_AW'(1);
      if (rx_push) rx_wp_q <= rx_wp_q + RX_AW'(1);
      if (rx_pop)  rx_rp_q <= rx_rp_q + RX_AW'(1);
      tx_cnt_q   <= tx_cnt_d;
      rx_cnt_q   <= rx_cnt_d;
      tx_state_q <= tx_state_d;
      gap_q      <= gap_d;
      rx_state_q <= rx_state_d;
      poll_q     <= poll_d;
      if (acc_wr && bus_addr == 2'd0 && tx_full)            tx_drop_q <= 1'b1;
      else if (acc_wr && bus_addr == 2'd1 && bus_wdata[3])  tx_drop_q <= 1'b0;
      if (acc_wr && bus_addr == 2'd2) ctrl_q <= bus_wdata[3:0];
    end
  end

  // Registered outputs; strobes follow the FSMs' next state so they align with SEND/PROBE
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_rdata_q  <= '0;
      bus_ready_q  <= 1'b0;
      tx_wr_en_q   <= 1'b0;
      tx_wr_data_q <= '0;
      rx_rd_en_q   <= 1'b0;
      irq_q        <= 1'b0;
    end else begin
      bus_ready_q <= bus_sel;
      bus_rdata_q <= acc_rd ? rd_mux : '0;
      tx_wr_en_q  <= (tx_state_d == TXS_SEND);
      if (tx_state_d == TXS_SEND) tx_wr_data_q <= tx_mem_q[tx_rp_q];
      rx_rd_en_q  <= (rx_state_d == RXS_PROBE);
      irq_q       <= (ctrl_q[2] & ~rx_empty) | (ctrl_q[3] & tx_idle);
    end
  end

  assign bus_rdata  = bus_rdata_q;
  assign bus_ready  = bus_ready_q;
  assign tx_wr_en   = tx_wr_en_q;
  assign tx_wr_data = tx_wr_data_q;
  assign rx_rd_en   = rx_rd_en_q;
  assign irq        = irq_q;

endmodule

// File: tb/tb_uart_mmio.sv
// tb_uart_mmio: directed bench with a transaction-level reference model that
// is compared against every registered output each cycle.
module tb_uart_mmio;
  localparam int unsigned TXD  = 8;
  localparam int unsigned RXD  = 8;
  localparam int unsigned GAP  = 4;
  localparam int unsigned POLL = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        bus_sel = 1'b0;
  logic        bus_we = 1'b0;
  logic [1:0]  bus_addr = 2'd0;
  logic [31:0] bus_wdata = 32'd0;
  logic [31:0] bus_rdata;
  logic        bus_ready;
  logic        tx_wr_en;
  logic [7:0]  tx_wr_data;
  logic        rx_rd_en;
  logic [7:0]  rx_data_r = 8'd0;
  logic        rx_valid_r = 1'b0;
  logic        irq;

  always #5 clk = ~clk;

  uart_mmio #(.TX_DEPTH(TXD), .RX_DEPTH(RXD), .TX_GAP(GAP), .RX_POLL(POLL)) dut (
    .clk(clk), .rst(rst), .bus_sel(bus_sel), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ready(bus_ready),
    .tx_wr_en(tx_wr_en), .tx_wr_data(tx_wr_data), .rx_rd_en(rx_rd_en),
    .rx_rd_data(rx_data_r), .rx_rd_valid(rx_valid_r), .irq(irq)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Serial-port stand-in: answers a probe with the next queued byte one cycle later
  byte unsigned src[$];
  always @(posedge clk) begin
    rx_valid_r <= 1'b0;
    if (rx_rd_en === 1'b1 && src.size() > 0) begin
      rx_valid_r <= 1'b1;
      rx_data_r  <= src.pop_front();
    end
  end

  // Observed TX strobes and RX probes
  int          plog_t[$];
  logic [7:0]  plog_d[$];
  int          probes = 0;
  always @(negedge clk) begin
    if (tx_wr_en === 1'b1) begin
      plog_t.push_back(cyc);
      plog_d.push_back(tx_wr_data);
    end
    if (rx_rd_en === 1'b1) probes++;
  end

  // Reference model: queues plus countdowns for send cooldown and poll interval
  byte unsigned mtx[$], mrx[$];
  bit          m_drop = 1'b0, m_send = 1'b0, m_probe = 1'b0, m_capt = 1'b0;
  bit [3:0]    m_ctrl = 4'h3;
  int          m_cool = 0, m_wait = POLL;
  bit          e_ready = 1'b0, e_rd = 1'b0, e_txen = 1'b0, e_rxen = 1'b0, e_irq = 1'b0;
  logic [7:0]  e_txd = 8'd0;
  logic [31:0] e_rdata = 32'd0;

  always @(posedge clk) begin : model
    bit tidle, tfull, rfull, nsend, nprobe;
    int st;
    if (rst) begin
      mtx.delete(); mrx.delete();
      m_drop = 1'b0; m_ctrl = 4'h3; m_send = 1'b0; m_cool = 0;
      m_probe = 1'b0; m_capt = 1'b0; m_wait = POLL;
      e_ready = 1'b0; e_rd = 1'b0; e_txen = 1'b0; e_rxen = 1'b0; e_irq = 1'b0; e_rdata = 32'd0;
    end else begin
      tfull = (mtx.size() == TXD);
      rfull = (mrx.size() == RXD);
      tidle = (mtx.size() == 0) && !m_send && (m_cool == 0);
      st = (mrx.size() << 16) | (mtx.size() << 8) | (int'(m_drop) << 3) |
           (int'(tidle) << 2) | (int'(tfull) << 1) | int'(mrx.size() > 0);
      e_ready = bus_sel;
      e_rd    = bus_sel && !bus_we;
      e_rdata = 32'd0;
      if (e_rd) begin
        case (bus_addr)
          2'd0:    e_rdata = (mrx.size() > 0) ? 32'(mrx[0]) : 32'd0;
          2'd1:    e_rdata = 32'(st);
          2'd2:    e_rdata = 32'(m_ctrl);
          default: e_rdata = 32'd0;
        endcase
      end
      e_irq = (m_ctrl[2] && mrx.size() > 0) || (m_ctrl[3] && tidle);
      // transmit: a strobe, then GAP quiet cycles, then one idle decision cycle
      nsend = 1'b0;
      if (m_send) begin
        void'(mtx.pop_front());
        m_cool = GAP;
      end else if (m_cool > 0) begin
        m_cool--;
      end else if (m_ctrl[0] && mtx.size() > 0) begin
        nsend = 1'b1;
        e_txd = mtx[0];
      end
      m_send = nsend;
      e_txen = nsend;
      // CPU pop returns the old head before any same-cycle capture lands
      if (e_rd && bus_addr == 2'd0 && mrx.size() > 0) void'(mrx.pop_front());
      nprobe = 1'b0;
      if (m_capt) begin
        if (rx_valid_r === 1'b1) mrx.push_back(rx_data_r);
        m_capt = 1'b0;
        m_wait = POLL;
      end else if (m_probe) begin
        m_probe = 1'b0;
        m_capt  = 1'b1;
      end else if (m_wait > 1) begin
        m_wait--;
      end else if (m_ctrl[1] && !rfull) begin
        nprobe = 1'b1;
      end
      m_probe = nprobe;
      e_rxen  = nprobe;
      if (bus_sel && bus_we) begin
        case (bus_addr)
          2'd0: if (tfull) m_drop = 1'b1; else mtx.push_back(bus_wdata[7:0]);
          2'd1: if (bus_wdata[3]) m_drop = 1'b0;
          2'd2: m_ctrl = bus_wdata[3:0];
          default: ;
        endcase
      end
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    chk("bus_ready", 32'(bus_ready), 32'(e_ready));
    chk("tx_wr_en", 32'(tx_wr_en), 32'(e_txen));
    if (e_txen) chk("tx_wr_data", 32'(tx_wr_data), 32'(e_txd));
    chk("rx_rd_en", 32'(rx_rd_en), 32'(e_rxen));
    chk("irq", 32'(irq), 32'(e_irq));
    if (e_ready && e_rd) chk("bus_rdata", bus_rdata, e_rdata);
  end

  task automatic drive(input logic s, input logic w, input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    bus_sel = s; bus_we = w; bus_addr = a; bus_wdata = d;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 2'd0, 32'd0);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    drive(1'b1, 1'b1, a, d);
    drive(1'b0, 1'b0, 2'd0, 32'd0);
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    drive(1'b1, 1'b0, a, 32'd0);
    drive(1'b0, 1'b0, 2'd0, 32'd0);
    chk("rd_ack", 32'(bus_ready), 32'd1);
    d = bus_rdata;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    logic [31:0] d;
    int t0, p0;

    // reset for three cycles
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_rdata", bus_rdata, 32'd0);
    chk("rst_ready", 32'(bus_ready), 32'd0);
    chk("rst_txen", 32'(tx_wr_en), 32'd0);
    chk("rst_txdata", 32'(tx_wr_data), 32'd0);
    chk("rst_rxen", 32'(rx_rd_en), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    bus_read(2'd1, d); chk("rst_status", d, 32'h0000_0004);
    bus_read(2'd2, d); chk("rst_ctrl", d, 32'h0000_0003);
    bus_read(2'd3, d); chk("reserved_rd", d, 32'd0);

    // TX pacing: three back-to-back DATA writes
    plog_t.delete(); plog_d.delete();
    drive(1'b1, 1'b1, 2'd0, 32'h41); t0 = cyc;
    drive(1'b1, 1'b1, 2'd0, 32'h42);
    drive(1'b1, 1'b1, 2'd0, 32'h43);
    idle(30);
    chk("pace_cnt", 32'(plog_t.size()), 32'd3);
    if (plog_t.size() == 3) begin
      chk("pace_t0", 32'(plog_t[0] - t0), 32'd2);
      chk("pace_t1", 32'(plog_t[1] - t0), 32'd8);
      chk("pace_t2", 32'(plog_t[2] - t0), 32'd14);
      chk("pace_d0", 32'(plog_d[0]), 32'h41);
      chk("pace_d1", 32'(plog_d[1]), 32'h42);
      chk("pace_d2", 32'(plog_d[2]), 32'h43);
    end
    bus_read(2'd1, d); chk("pace_idle", d, 32'h0000_0004);

    // TX overflow with the sender disabled
    bus_write(2'd2, 32'h2);
    for (int i = 1; i <= 9; i++) drive(1'b1, 1'b1, 2'd0, 32'(i));
    idle(1);
    bus_read(2'd1, d); chk("ovf_status", d, 32'h0000_080A);
    bus_write(2'd1, 32'h8);
    bus_read(2'd1, d); chk("ovf_clr", d, 32'h0000_0802);
    plog_t.delete(); plog_d.delete();
    bus_write(2'd2, 32'h3);
    idle(60);
    chk("ovf_cnt", 32'(plog_d.size()), 32'd8);
    if (plog_d.size() == 8) begin
      for (int i = 0; i < 8; i++) chk("ovf_byte", 32'(plog_d[i]), 32'(i + 1));
      chk("ovf_gap", 32'(plog_t[7] - plog_t[6]), 32'd6);
    end
    bus_read(2'd1, d); chk("ovf_idle", d, 32'h0000_0004);

    // RX path with the RX interrupt enabled
    bus_write(2'd2, 32'h7);
    src.push_back(8'h5A);
    idle(40);
    bus_read(2'd1, d); chk("rx_status", d, 32'h0001_0005);
    chk("rx_irq_hi", 32'(irq), 32'd1);
    bus_read(2'd0, d); chk("rx_data", d, 32'h0000_005A);
    bus_read(2'd0, d); chk("rx_empty_rd", d, 32'd0);
    idle(2);
    chk("rx_irq_lo", 32'(irq), 32'd0);

    // RX backpressure: nine bytes offered to an eight-deep FIFO
    bus_write(2'd2, 32'h3);
    for (int i = 0; i < 9; i++) src.push_back(8'(8'hA0 + i));
    idle(250);
    chk("bp_left", 32'(src.size()), 32'd1);
    bus_read(2'd1, d); chk("bp_status", d, 32'h0008_0005);
    p0 = probes;
    idle(40);
    chk("bp_noprobe", 32'(probes - p0), 32'd0);
    bus_read(2'd0, d); chk("bp_data", d, 32'h0000_00A0);
    idle(40);
    chk("bp_resume", 32'(src.size()), 32'd0);
    bus_read(2'd1, d); chk("bp_refill", d, 32'h0008_0005);

    // reset while the sender is in its gap with three bytes queued
    plog_t.delete(); plog_d.delete();
    drive(1'b1, 1'b1, 2'd0, 32'h11); t0 = cyc;
    drive(1'b1, 1'b1, 2'd0, 32'h12);
    drive(1'b1, 1'b1, 2'd0, 32'h13);
    drive(1'b1, 1'b1, 2'd0, 32'h14);
    @(negedge clk);
    bus_sel = 1'b0; bus_we = 1'b0; rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle(40);
    chk("mid_cnt", 32'(plog_t.size()), 32'd1);
    if (plog_t.size() == 1) begin
      chk("mid_t", 32'(plog_t[0] - t0), 32'd2);
      chk("mid_d", 32'(plog_d[0]), 32'h11);
    end
    bus_read(2'd1, d); chk("mid_status", d, 32'h0000_0004);
    bus_read(2'd2, d); chk("mid_ctrl", d, 32'h0000_0003);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
